// File: rtl/eth_tx_min_frame_pad.sv
// Pads short Ethernet TX frames with zero bytes up to the 802.3 minimum and rewrites trailing-bytes tuser.
// Optional registered output with skid buffer: define ETH_TX_PAD_OUT_REG_EN.
module eth_tx_min_frame_pad #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned PREAMBLE_BYTES  = 6,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned USER_W          = $clog2(DATA_WIDTH/8) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic [USER_W-1:0]     i_tuser,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic [USER_W-1:0]     o_tuser,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned TOTAL_MIN = PREAMBLE_BYTES + MIN_FRAME_BYTES;
    localparam int unsigned MIN_WORDS = (TOTAL_MIN + BYTES - 1) / BYTES;
    localparam int unsigned MIN_TRAIL = TOTAL_MIN % BYTES;
    localparam int unsigned CNT_W     = $clog2(MIN_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MIN_WORDS - 1);
    localparam logic [CNT_W-1:0]  SAT_CNT   = CNT_W'(MIN_WORDS);
    localparam logic [USER_W-1:0] TRAIL_VAL = USER_W'(MIN_TRAIL);

    if (TOTAL_MIN < BYTES || BYTES < 8 || (BYTES & (BYTES - 1)) != 0) begin : g_bad_cfg
        $error("eth_tx_min_frame_pad: invalid DATA_WIDTH / minimum frame configuration");
    end

    typedef enum logic {S_PASS, S_PAD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    int unsigned       vb;
    logic              short_open;

    // Core stage result, before the optional output register
    logic [DATA_WIDTH-1:0] c_tdata;
    logic [USER_W-1:0]     c_tuser;
    logic                  c_tlast;
    logic                  c_tvalid;
    logic                  c_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PASS;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        c_tvalid   = 1'b0;
        c_tdata    = i_tdata;
        c_tuser    = '0;
        c_tlast    = 1'b0;
        i_tready   = 1'b0;
        short_open = 1'b0;
        vb         = (i_tuser == '0) ? BYTES : 32'(i_tuser);

        case (state_q)
            S_PASS: begin
                i_tready = c_tready;
                c_tvalid = i_tvalid;
                c_tlast  = i_tlast;
                if (i_tlast) begin
                    c_tuser = i_tuser;
                    if (32'(word_cnt_q) * BYTES + vb < TOTAL_MIN) begin
                        for (int unsigned b = 0; b < BYTES; b++) begin
                            if (b >= vb) c_tdata[b*8 +: 8] = 8'h00;
                        end
                        if (word_cnt_q == LAST_CNT) begin
                            c_tuser = TRAIL_VAL;
                        end else begin
                            c_tlast    = 1'b0;
                            c_tuser    = '0;
                            short_open = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                c_tvalid = 1'b1;
                c_tdata  = '0;
                if (word_cnt_q == LAST_CNT) begin
                    c_tlast = 1'b1;
                    c_tuser = TRAIL_VAL;
                end
            end
            default: state_d = S_PASS;
        endcase

        // Word accounting on each accepted output beat
        if (c_tvalid && c_tready) begin
            if (c_tlast) begin
                word_cnt_d = '0;
                state_d    = S_PASS;
            end else begin
                if (word_cnt_q != SAT_CNT) word_cnt_d = word_cnt_q + CNT_W'(1);
                if (short_open) state_d = S_PAD;
            end
        end
    end

`ifdef ETH_TX_PAD_OUT_REG_EN
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_tdata_q;
    logic [USER_W-1:0]     skid_tuser_q;
    logic                  skid_tlast_q;

    // Core accepts whenever the skid slot is free, so i_tready never sees o_tready directly
    assign c_tready = ~skid_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tvalid     <= 1'b0;
            o_tdata      <= '0;
            o_tuser      <= '0;
            o_tlast      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_tdata_q <= '0;
            skid_tuser_q <= '0;
            skid_tlast_q <= 1'b0;
        end else if (o_tready || !o_tvalid) begin
            if (skid_valid_q) begin
                o_tvalid     <= 1'b1;
                o_tdata      <= skid_tdata_q;
                o_tuser      <= skid_tuser_q;
                o_tlast      <= skid_tlast_q;
                skid_valid_q <= 1'b0;
            end else begin
                o_tvalid <= c_tvalid;
                if (c_tvalid) begin
                    o_tdata <= c_tdata;
                    o_tuser <= c_tuser;
                    o_tlast <= c_tlast;
                end
            end
        end else if (c_tvalid && c_tready) begin
            skid_valid_q <= 1'b1;
            skid_tdata_q <= c_tdata;
            skid_tuser_q <= c_tuser;
            skid_tlast_q <= c_tlast;
        end
    end
`else
    assign c_tready = o_tready;
    assign o_tvalid = c_tvalid;
    assign o_tdata  = c_tdata;
    assign o_tuser  = c_tuser;
    assign o_tlast  = c_tlast;
`endif

endmodule

// File: tb/tb_eth_tx_min_frame_pad.sv
// Scoreboard bench for eth_tx_min_frame_pad: driver pushes expected beats, negedge monitor pops and compares.
module tb_eth_tx_min_frame_pad;

    localparam int unsigned DW = 64;
    localparam int unsigned UW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] i_tdata;
    logic [UW-1:0] i_tuser;
    logic          i_tlast;
    logic          i_tvalid;
    logic          i_tready;
    logic [DW-1:0] o_tdata;
    logic [UW-1:0] o_tuser;
    logic          o_tlast;
    logic          o_tvalid;
    logic          o_tready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    stall_cnt = 0;
    int    beat_no   = 0;
    bit    mon_en    = 1'b0;
    bit    rnd_ready = 1'b0;

    eth_tx_min_frame_pad #(
        .DATA_WIDTH(64), .PREAMBLE_BYTES(6), .MIN_FRAME_BYTES(60), .USER_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] wgen(input int fid, input int k);
        logic [7:0] a, b;
        a = 8'(fid + 17);
        b = 8'(k + 33);
        return {a, b, a ^ 8'h5A, b ^ 8'hA5, a + 8'd1, b + 8'd2, a ^ b ^ 8'h3C, 8'hEE};
    endfunction

    // Byte-count model: frames under 66 bytes become 9 words, last word masked, tail 2
    task automatic push_frame(input int fid, input int n, input int tu);
        int    vb, total, nout;
        bit    is_short;
        beat_t b;
        vb       = (tu == 0) ? 8 : tu;
        total    = (n - 1) * 8 + vb;
        is_short = (total < 66);
        nout     = is_short ? 9 : n;
        for (int k = 0; k < nout; k++) begin
            if (k < n) b.data = wgen(fid, k);
            else       b.data = '0;
            if (is_short && k == n - 1) begin
                for (int j = vb; j < 8; j++) b.data[j*8 +: 8] = 8'h00;
            end
            b.last = (k == nout - 1);
            b.user = b.last ? (is_short ? 4'd2 : 4'(tu)) : 4'd0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_frame(input int fid, input int n, input int tu);
        int budget;
        bit hs;
        push_frame(fid, n, tu);
        for (int k = 0; k < n; k++) begin
            i_tvalid = 1'b1;
            i_tdata  = wgen(fid, k);
            i_tlast  = (k == n - 1);
            i_tuser  = (k == n - 1) ? 4'(tu) : 4'd0;
            hs       = 1'b0;
            budget   = 0;
            while (!hs && budget < 200) begin
                @(negedge clk);
                hs = i_tready;
                @(posedge clk);
                #1;
                budget++;
            end
            if (!hs) chk(1'b0, "in_handshake_timeout", 80'(budget), 80'd200);
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tuser  = '0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk(exp_q.size() == 0, name, 80'(exp_q.size()), 80'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops on each output handshake, checks hold-stability under stall
    initial begin
        beat_t e, cur, prev;
        bit    stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            cur = {o_tdata, o_tuser, o_tlast};
            if (!rst_n || !mon_en) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk(o_tvalid && cur == prev, "stall_stable", 80'(cur), 80'(prev));
                if (o_tvalid && o_tready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", 80'(cur), 80'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(cur == e, $sformatf("beat%0d", beat_no), 80'(cur), 80'(e));
                    end
                    beat_no++;
                    if (!i_tready) stall_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = o_tvalid;
                    prev    = cur;
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        i_tdata  = '0;
        i_tuser  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(o_tvalid == 1'b0, "reset_o_tvalid", 80'(o_tvalid), 80'd0);
        chk(i_tready == 1'b1, "reset_i_tready", 80'(i_tready), 80'd1);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        stall_cnt = 0;
        send_frame(1, 10, 0);
        drain("drain_long80");
        chk(stall_cnt == 0, "stall_long80", 80'(stall_cnt), 80'd0);

        stall_cnt = 0;
        send_frame(2, 6, 4);
        drain("drain_short44");
        chk(stall_cnt == 3, "stall_short44", 80'(stall_cnt), 80'd3);

        stall_cnt = 0;
        send_frame(3, 9, 1);
        drain("drain_65b");
        chk(stall_cnt == 0, "stall_65b", 80'(stall_cnt), 80'd0);

        send_frame(4, 9, 2);
        drain("drain_66b");

        rnd_ready = 1'b1;
        send_frame(5, 2, 3);
        send_frame(6, 12, 0);
        drain("drain_b2b");
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset while padding: enter PAD with a 1-word frame, then pulse rst_n
        mon_en   = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = wgen(7, 0);
        i_tlast  = 1'b1;
        i_tuser  = 4'd0;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        @(negedge clk);
        chk(o_tvalid == 1'b1, "pad_active", 80'(o_tvalid), 80'd1);
        chk(i_tready == 1'b0, "pad_i_tready", 80'(i_tready), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk(o_tvalid == 1'b0, "rst_in_pad_o_tvalid", 80'(o_tvalid), 80'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk(o_tvalid == 1'b0, "post_rst_o_tvalid", 80'(o_tvalid), 80'd0);
        chk(i_tready == 1'b1, "post_rst_i_tready", 80'(i_tready), 80'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send_frame(8, 1, 0);
        drain("drain_post_rst");

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_min_frame_pad.md
# eth_tx_min_frame_pad

Pads outgoing Ethernet frames to the IEEE 802.3 minimum length before they reach the MAC. It sits directly downstream of the UDP/IPv4 header inserter and upstream of the TX MAC/FCS generator. It consumes word-aligned frames that carry a leading preamble gap and a trailing-bytes tuser. Short frames are extended with zero bytes so the frame body, excluding preamble and FCS, is at least MIN_FRAME_BYTES; trailing-bytes tuser is rewritten to match.

## Interface
- DATA_WIDTH, 64: stream width in bits; BYTES = DATA_WIDTH/8, power of two ≥ 8.
- PREAMBLE_BYTES, 6: leading bytes ahead of the Ethernet DST MAC.
- MIN_FRAME_BYTES, 60: minimum frame bytes, excluding preamble and FCS.
- USER_W, $clog2(DATA_WIDTH/8)+1: tuser width. tuser is the trailing-byte count on the tlast word; 0 means a full word.
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_tdata  in  DATA_WIDTH  byte 0 in bits [7:0].
- i_tuser  in  USER_W  trailing bytes; meaningful only with i_tlast.
- i_tlast, i_tvalid  in  1 each.
- i_tready  out  1.
- o_tdata  out  DATA_WIDTH.
- o_tuser  out  USER_W.
- o_tlast, o_tvalid  out  1 each.
- o_tready  in  1.

## Operation
- Derived constants:
  - TOTAL_MIN = PREAMBLE_BYTES + MIN_FRAME_BYTES.
  - MIN_WORDS = ceil(TOTAL_MIN/BYTES).
  - MIN_TRAIL = TOTAL_MIN mod BYTES (0 means full).
  - Elaboration error if TOTAL_MIN < BYTES.
- word_cnt counts output words accepted in the current frame. It saturates at MIN_WORDS and clears after each o_tlast handshake.
- vb (valid bytes of the input last word) = i_tuser==0 ? BYTES : i_tuser.
- State PASS:
  - i_tready = o_tready; data, tuser and tlast are passed through.
  - Short-frame test on the i_tlast word: word_cnt*BYTES + vb < TOTAL_MIN.
  - Short, with word_cnt == MIN_WORDS-1: emit the word with bytes ≥ vb zeroed, tlast=1, tuser=MIN_TRAIL. Stay in PASS.
  - Short, with word_cnt < MIN_WORDS-1: emit the word with bytes ≥ vb zeroed and tlast=0. On handshake, go to PAD.
  - Not short: the word is passed unchanged.
- State PAD:
  - i_tready=0, o_tvalid=1, o_tdata=0.
  - o_tlast=1 and o_tuser=MIN_TRAIL when word_cnt == MIN_WORDS-1; otherwise tlast=0, tuser=0.
  - On the handshake of that final word, return to PASS.
- o_tuser is 0 on non-last words. Long frames are never modified, including frames with MIN_WORDS or more words.
- Pad bytes are always zero.

## Timing
- Without the output register, PASS is combinational (0-cycle latency). The FSM and word_cnt are the only sequential state.
- AXI-Stream rules:
  - Each beat transfers on tvalid&&tready.
  - o_tvalid is never dependent on o_tready.
  - Output data is stable while stalled.
- Padding inserts exactly MIN_WORDS-1-word_cnt extra output beats; i_tready is low for those beats.
- Back-to-back frames: the cycle after the last pad handshake, i_tready follows o_tready again. No extra bubble.
- Reset values:
  - state=PASS, word_cnt=0.
  - o_tvalid=0 in PAD-derived paths.
  - With the output register: o_tvalid=0, o_tdata=0, o_tuser=0, o_tlast=0.
- Reset mid-PAD or mid-frame abandons the frame; downstream sees no tlast. The first frame after reset is processed from word 0.
- Input tlast with i_tuser > BYTES-1 is illegal; no checking is required.

## Configuration
- ETH_TX_PAD_OUT_REG_EN defined:
  - Adds a 1-entry registered output stage with full-throughput skid buffering. Latency becomes 1 cycle.
  - i_tready depends only on registered state, never combinationally on o_tready.
  - Throughput is still one beat per cycle.
- Undefined: the combinational 0-latency path described above.

## Test plan
All cases use DATA_WIDTH=64, PREAMBLE_BYTES=6, MIN_FRAME_BYTES=60, which gives TOTAL_MIN=66, MIN_WORDS=9, MIN_TRAIL=2.
- 10 full words, last tuser=0 (80 B) -> 10 output words bit-identical to input; tlast on word 10, tuser=0; no i_tready stall.
- 6 words, last tuser=4 (44 B) -> 9 output words:
  - word 6 bytes 4–7 are zero;
  - words 7–9 are all-zero;
  - tlast on word 9 with tuser=2;
  - i_tready low for exactly 3 accepted output beats.
- 9 words, last tuser=1 (65 B) -> 9 output words, no PAD state; last word byte 1 zero, tuser=2.
- 9 words, last tuser=2 (exactly 66 B) -> unchanged; tuser=2.
- Back-to-back frames with random 50% o_tready:
  - a 2-word frame, last tuser=3, becomes 9 words with tuser=2;
  - it is immediately followed by a 12-word frame, which is unchanged;
  - no lost, duplicated or reordered beats; data is stable under stall.
- rst_n low for 1 cycle while in PAD -> o_tvalid=0 and state=PASS. A following 1-word frame with tuser=0 becomes 9 words ending with tuser=2.
